// File: rtl/mem_lsu.sv
// Load/store unit for the hxd32 MEM stage: one request in, one RAM beat (or two for
// word-crossing accesses), one response out, with load alignment and sign/zero extension.
module mem_lsu #(
   parameter int XLEN        = 32,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_wr_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_signed_i,
   input  logic [XLEN-1:0]   req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              dram_en_o,
   output logic [XLEN-1:0]   dram_addr_o,
   output logic [XLEN/8-1:0] dram_wr_byte_en_o,
   output logic [XLEN-1:0]   dram_wr_data_o,
   input  logic [XLEN-1:0]   dram_rd_data_i,
   output logic              rsp_valid_o,
   output logic [XLEN-1:0]   rsp_rdata_o,
   output logic              rsp_err_o
);

   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_wr;
   logic              r_signed;
   logic [1:0]        r_size;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_lo;

   logic              w_accept;
   logic              w_req_err;
   logic [2*NB-1:0]   w_mask;
   logic              w_split;
   logic              w_err;
   logic [OB-1:0]     w_off;
   logic [XLEN-1:0]   w_word_addr;
   logic [2*XLEN-1:0] w_wshift;
   logic [XLEN-1:0]   w_rd_hi;
   logic [XLEN-1:0]   w_rd_lo;
   logic [2*XLEN-1:0] w_rcat;
   logic [XLEN-1:0]   w_rext;

   // Byte footprint of an access across two adjacent words; upper half set means a split.
   function automatic logic [2*NB-1:0] f_mask(input logic [1:0] size, input logic [OB-1:0] off);
      logic [2*NB-1:0] base;
      base = '0;
      for (int i = 0; i < 8; i++)
         if (i < (1 << size)) base[i] = 1'b1;
      return base << off;
   endfunction

   function automatic logic f_err(input logic [1:0] size, input logic [2*NB-1:0] mask);
      return ((size == 2'd3) && (XLEN == 32)) || ((|mask[2*NB-1:NB]) && !MISALIGN_EN);
   endfunction

   assign w_off       = r_addr[OB-1:0];
   assign w_mask      = f_mask(r_size, w_off);
   assign w_split     = |w_mask[2*NB-1:NB];
   assign w_err       = f_err(r_size, w_mask);
   assign w_req_err   = f_err(req_size_i, f_mask(req_size_i, req_addr_i[OB-1:0]));
   assign w_accept    = req_valid_i & req_ready_o;
   assign w_word_addr = {r_addr[XLEN-1:OB], {OB{1'b0}}};
   assign w_wshift    = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};

   // Beat 0 was parked in r_lo on a split; otherwise the single beat is the low word.
   assign w_rd_hi = w_split ? dram_rd_data_i : {XLEN{1'b0}};
   assign w_rd_lo = w_split ? r_lo : dram_rd_data_i;
   assign w_rcat  = {w_rd_hi, w_rd_lo} >> {w_off, 3'b000};

   always_comb begin
      int nbits;
      nbits  = 8 << r_size;
      w_rext = '0;
      for (int i = 0; i < XLEN; i++)
         w_rext[i] = (i < nbits) ? w_rcat[i] : (r_signed & w_rcat[nbits-1]);
   end

   always_comb begin
      // NOTE: every output and next-state is given a default first, so no path can infer a latch.
      w_next            = r_state;
      req_ready_o       = 1'b0;
      dram_en_o         = 1'b0;
      dram_addr_o       = '0;
      dram_wr_byte_en_o = '0;
      dram_wr_data_o    = '0;
      rsp_valid_o       = 1'b0;
      rsp_rdata_o       = '0;
      rsp_err_o         = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) w_next = w_req_err ? S_RESP : S_ISSUE0;
         end
         S_ISSUE0: begin
            dram_en_o         = 1'b1;
            dram_addr_o       = w_word_addr;
            dram_wr_byte_en_o = r_wr ? w_mask[NB-1:0] : '0;
            dram_wr_data_o    = w_wshift[XLEN-1:0];
            w_next            = w_split ? S_ISSUE1 : S_RESP;
         end
         S_ISSUE1: begin
            dram_en_o         = 1'b1;
            dram_addr_o       = w_word_addr + XLEN'(NB);
            dram_wr_byte_en_o = r_wr ? w_mask[2*NB-1:NB] : '0;
            dram_wr_data_o    = w_wshift[2*XLEN-1:XLEN];
            w_next            = S_RESP;
         end
         S_RESP: begin
            req_ready_o = 1'b1;
            rsp_valid_o = 1'b1;
            rsp_err_o   = w_err;
            rsp_rdata_o = (!r_wr && !w_err) ? w_rext : '0;
            if (req_valid_i) w_next = w_req_err ? S_RESP : S_ISSUE0;
            else             w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_lo    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_ISSUE1 && !r_wr) r_lo <= dram_rd_data_i;
      end
   end

   // NOTE: request capture registers carry no reset; they are only observed after an accept loads them.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_wr     <= req_wr_i;
         r_size   <= req_size_i;
         r_signed <= req_signed_i;
         r_addr   <= req_addr_i;
         r_wdata  <= req_wdata_i;
      end
   end

endmodule
